stage_ctx_fifo: RTL and testbench

Parametrised per-job context queue for the modular-multiply pipeline. It captures a stage number and an mm-info word each time a job enters (en_a/en_c) and retires one entry each time a job leaves (en_out_a/en_out_c). It drives a registered context output at a configurable point in the cnt_4/cnt_3 sequences. Unlike the fixed 4-entry predecessor, it adds full/empty/level status, overflow/underflow protection with sticky error flags, and configurable widths, depth and load points.

---
 rtl/stage_ctx_fifo.sv | 171 +++++++++++++++++
 tb/tb_stage_ctx_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_ctx_fifo.sv
// ---------------------------------------------------------------------------
// stage_ctx_fifo
//
// Per-job context queue for the modular-multiply pipeline. Each job entering
// the pipeline (en_a / en_c) enqueues its stage number and mm-info word. Each
// job leaving (en_out_a / en_out_c) retires the head entry. When either
// sequence counter reaches its load point, the head entry is copied into the
// registered context outputs.
//
// The queue reports its level and full/empty status. Pushes while full and
// pops or loads while empty are refused, and they raise sticky error flags.
//
// Optional build macro:
//   STAGE_CTX_FIFO_BYPASS_EN
//     When this macro is defined, a load on an empty queue that coincides
//     with a push captures the incoming data directly into the outputs, and
//     underflow is not raised. The pushed entry is still enqueued.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   en_a, en_c            push requests (ORed)
//   en_out_a, en_out_c    pop requests (ORed)
//   cnt_4, cnt_3          sequence counters that select the load point
//   stage_num_in          stage number to enqueue
//   mm_info_in            mm-info word to enqueue
//   err_clr               synchronous clear of the sticky error flags
//   stage_num_out         registered stage number of the loaded entry
//   mm_info_out           registered mm-info of the loaded entry
//   full, empty, level    occupancy status (combinational from level)
//   overflow              sticky: push refused while full
//   underflow             sticky: pop or load attempted while empty
// ---------------------------------------------------------------------------
module stage_ctx_fifo #(
  parameter int STAGE_W       = 2,
  parameter int INFO_W        = 8,
  parameter int DEPTH_LOG2    = 2,
  parameter int CNT_W         = 3,
  parameter int LOAD_CNT4_VAL = 2,
  parameter int LOAD_CNT3_VAL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_a,
  input  logic                  en_c,
  input  logic                  en_out_a,
  input  logic                  en_out_c,
  input  logic [CNT_W-1:0]      cnt_4,
  input  logic [CNT_W-1:0]      cnt_3,
  input  logic [STAGE_W-1:0]    stage_num_in,
  input  logic [INFO_W-1:0]     mm_info_in,
  input  logic                  err_clr,
  output logic [STAGE_W-1:0]    stage_num_out,
  output logic [INFO_W-1:0]     mm_info_out,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  // A one-entry queue still needs a 1-bit pointer; that pointer is held at 0.
  localparam int PTR_W   = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int ENTRY_W = STAGE_W + INFO_W;

  localparam logic [CNT_W-1:0]    LOAD4     = CNT_W'(LOAD_CNT4_VAL);
  localparam logic [CNT_W-1:0]    LOAD3     = CNT_W'(LOAD_CNT3_VAL);
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0] level_q;

  logic push;
  logic pop;
  logic load;
  logic push_ok;
  logic pop_ok;
  logic load_ok;
  logic bypass_hit;
  logic overflow_set;
  logic underflow_set;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (DEPTH == 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign push = en_a | en_c;
  assign pop  = en_out_a | en_out_c;
  assign load = (cnt_4 == LOAD4) | (cnt_3 == LOAD3);

  assign level = level_q;
  assign full  = (level_q == DEPTH_LVL);
  assign empty = (level_q == '0);

  // When the queue is full, a pop frees a slot in the same cycle. This lets
  // a push that coincides with the pop still be accepted.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign load_ok = load & ~empty;

`ifdef STAGE_CTX_FIFO_BYPASS_EN
  assign bypass_hit = load & empty & push;
`else
  assign bypass_hit = 1'b0;
`endif

  assign overflow_set  = push & full & ~pop;
  assign underflow_set = empty & (pop | (load & ~bypass_hit));

  // Storage and pointers. The write lands at wr_ptr. The read pointer only
  // advances, so a same-cycle load still sees the pre-pop head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {stage_num_in, mm_info_in};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // The occupancy counter is kept separate from the pointers, so equal
  // pointers never leave full and empty ambiguous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Context outputs. A load reads existing storage, not the entry being
  // written in the same cycle. The bypass path is the only exception.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_num_out <= '0;
      mm_info_out   <= '0;
    end else if (load_ok) begin
      {stage_num_out, mm_info_out} <= mem[rd_ptr];
    end else if (bypass_hit) begin
      stage_num_out <= stage_num_in;
      mm_info_out   <= mm_info_in;
    end
  end

  // Sticky error flags. A new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~err_clr) | overflow_set;
      underflow <= (underflow & ~err_clr) | underflow_set;
    end
  end

endmodule

// File: tb/tb_stage_ctx_fifo.sv
// ---------------------------------------------------------------------------
// tb_stage_ctx_fifo
//
// Self-checking bench for stage_ctx_fifo with default parameters.
// A queue-based reference model holds the expected contents, outputs and
// sticky flags. All observable outputs are compared after every clock edge.
//
// The bench honours STAGE_CTX_FIFO_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_stage_ctx_fifo;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       en_a;
  logic       en_c;
  logic       en_out_a;
  logic       en_out_c;
  logic [2:0] cnt_4;
  logic [2:0] cnt_3;
  logic [1:0] stage_num_in;
  logic [7:0] mm_info_in;
  logic       err_clr;
  logic [1:0] stage_num_out;
  logic [7:0] mm_info_out;
  logic       full;
  logic       empty;
  logic [2:0] level;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [9:0] q[$];
  logic [1:0] m_stage;
  logic [7:0] m_info;
  logic       m_ov;
  logic       m_un;

  stage_ctx_fifo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_a          (en_a),
    .en_c          (en_c),
    .en_out_a      (en_out_a),
    .en_out_c      (en_out_c),
    .cnt_4         (cnt_4),
    .cnt_3         (cnt_3),
    .stage_num_in  (stage_num_in),
    .mm_info_in    (mm_info_in),
    .err_clr       (err_clr),
    .stage_num_out (stage_num_out),
    .mm_info_out   (mm_info_out),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("level",     32'(level),         32'(q.size()));
    checkOutput("full",      32'(full),          32'(q.size() == DEPTH));
    checkOutput("empty",     32'(empty),         32'(q.size() == 0));
    checkOutput("stage_out", 32'(stage_num_out), 32'(m_stage));
    checkOutput("info_out",  32'(mm_info_out),   32'(m_info));
    checkOutput("overflow",  32'(overflow),      32'(m_ov));
    checkOutput("underflow", 32'(underflow),     32'(m_un));
  endtask

  // One clock of queue semantics. Everything is decided from the occupancy
  // seen before the edge: a load reads the old head, a pop is ignored when
  // the queue is empty, and a push fits if a slot is free or a real pop
  // frees one.
  task automatic modelStep();
    bit psh;
    bit pp;
    bit ld;
    bit ov_set;
    bit un_set;
    int n;
    psh    = en_a | en_c;
    pp     = en_out_a | en_out_c;
    ld     = (cnt_4 == 3'd2) || (cnt_3 == 3'd4);
    ov_set = 1'b0;
    un_set = 1'b0;
    n      = q.size();
    if (ld) begin
      if (n > 0) begin
        {m_stage, m_info} = q[0];
      end else begin
`ifdef STAGE_CTX_FIFO_BYPASS_EN
        if (psh) {m_stage, m_info} = {stage_num_in, mm_info_in};
        else un_set = 1'b1;
`else
        un_set = 1'b1;
`endif
      end
    end
    if (pp) begin
      if (n > 0) void'(q.pop_front());
      else un_set = 1'b1;
    end
    if (psh) begin
      if (n < DEPTH || (pp && n > 0)) q.push_back({stage_num_in, mm_info_in});
      else ov_set = 1'b1;
    end
    m_ov = (m_ov & ~err_clr) | ov_set;
    m_un = (m_un & ~err_clr) | un_set;
  endtask

  task automatic applyStimulus(input logic a, input logic c, input logic oa, input logic oc,
                               input logic [2:0] c4, input logic [2:0] c3,
                               input logic [1:0] s, input logic [7:0] i, input logic clr);
    en_a         = a;
    en_c         = c;
    en_out_a     = oa;
    en_out_c     = oc;
    cnt_4        = c4;
    cnt_3        = c3;
    stage_num_in = s;
    mm_info_in   = i;
    err_clr      = clr;
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Reset is asserted mid-cycle and must take effect without a clock edge.
  // It is then held across one rising edge.
  task automatic doReset();
    en_a = 0; en_c = 0; en_out_a = 0; en_out_c = 0;
    cnt_4 = 0; cnt_3 = 0; err_clr = 0;
    rst_n = 1'b0;
    q.delete();
    m_stage = '0; m_info = '0; m_ov = 1'b0; m_un = 1'b0;
    #1;
    checkAll();
    @(posedge clk);
    #1;
    checkAll();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 0; en_c = 0; en_out_a = 0; en_out_c = 0;
    cnt_4 = 0; cnt_3 = 0; stage_num_in = 0; mm_info_in = 0; err_clr = 0;
    m_stage = '0; m_info = '0; m_ov = 1'b0; m_un = 1'b0;
    #12;
    checkAll();
    rst_n = 1'b1;

    // Basic push / load / pop / load flow.
    applyStimulus(1, 0, 0, 0, 0, 0, 2'd1, 8'h11, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 2'd2, 8'h22, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 2'd3, 8'h33, 0);
    checkOutput("tp1_level", 32'(level), 32'd3);
    applyStimulus(0, 0, 0, 0, 3'd2, 0, 0, 0, 0);
    checkOutput("tp1_stage_a", 32'(stage_num_out), 32'd1);
    checkOutput("tp1_info_a",  32'(mm_info_out),   32'h11);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 3'd4, 0, 0, 0);
    checkOutput("tp1_stage_b", 32'(stage_num_out), 32'd2);
    checkOutput("tp1_info_b",  32'(mm_info_out),   32'h22);

    // Overflow: five pushes into four slots.
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 2'(k), 8'(8'h40 + k), 0);
    end
    checkOutput("ovf_full",  32'(full),     32'd1);
    checkOutput("ovf_level", 32'(level),    32'd4);
    checkOutput("ovf_flag",  32'(overflow), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // While full, a simultaneous push and pop keeps the level.
    // Loads expose the wrap-around order.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1, 0, 1, 3'd2, 0, 2'(k + 1), 8'(8'h80 + k), 0);
    end
    checkOutput("wrap_ovf", 32'(overflow), 32'd0);

    // Drain with load+pop each cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 1, 0, 3'd2, 0, 0, 0, 0);
    end

    // Underflow on the empty queue, then clear.
    applyStimulus(0, 0, 1, 1, 3'd2, 0, 0, 0, 0);
    checkOutput("unf_flag", 32'(underflow), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("unf_clear", 32'(underflow), 32'd0);

    // Mid-operation reset with content present.
    applyStimulus(1, 0, 0, 0, 0, 0, 2'd3, 8'hC1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 2'd2, 8'hC2, 0);
    applyStimulus(1, 0, 0, 0, 3'd2, 0, 2'd1, 8'hC3, 0);
    doReset();
    checkOutput("rst_empty", 32'(empty), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 2'd1, 8'h5A, 0);
    applyStimulus(0, 0, 0, 0, 3'd2, 0, 0, 0, 0);
    checkOutput("rst_new_info", 32'(mm_info_out), 32'h5A);

    // Push and load on an empty queue.
    doReset();
    applyStimulus(1, 0, 0, 0, 3'd2, 0, 2'd2, 8'hA5, 0);
    checkOutput("byp_level", 32'(level), 32'd1);
`ifdef STAGE_CTX_FIFO_BYPASS_EN
    checkOutput("byp_info", 32'(mm_info_out), 32'hA5);
    checkOutput("byp_unf",  32'(underflow),   32'd0);
`else
    checkOutput("byp_info", 32'(mm_info_out), 32'h00);
    checkOutput("byp_unf",  32'(underflow),   32'd1);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom % 3) == 0, ($urandom % 4) == 0,
                    ($urandom % 3) == 0, ($urandom % 5) == 0,
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    2'($urandom), 8'($urandom), ($urandom % 10) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
